// File: rtl/trace_pkg.sv
// trace_pkg: shared record kinds, record layout and widths for the trace capture block
package trace_pkg;

    localparam int TAG_W  = 9;
    localparam int REC_DW = 64;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_REG  = 2'b01,
        KIND_MWR  = 2'b10,
        KIND_MRD  = 2'b11
    } kind_t;

    typedef struct packed {
        kind_t              kind;
        logic [TAG_W-1:0]   tag;
        logic [REC_DW-1:0]  data;
    } rec_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: record storage with two write ports and a show-ahead read port
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we0,
    input  rec_t                     i_d0,
    input  logic                     i_we1,
    input  rec_t                     i_d1,
    input  logic                     i_re,
    output rec_t                     o_head,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    rec_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;

    // port 1 always lands in the slot after port 0, so two pushes stay in order
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[r_wr_ptr] <= i_d0;
        if (i_we1) r_mem[r_wr_ptr + AW'(1)] <= i_d1;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_we0) + AW'(i_we1);
            r_rd_ptr <= r_rd_ptr + AW'(i_re);
            r_level  <= r_level + LW'(i_we0) + LW'(i_we1) - LW'(i_re);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/trace_capture.sv
// trace_capture: turns core register/memory activity into a FIFO of trace records
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    capture_en,
    input  logic                    reg_write_sig,
    input  logic [4:0]              reg_num,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [8:0]              addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [1:0]              rec_kind,
    output logic [8:0]              rec_tag,
    output logic [DATA_W-1:0]       rec_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             drop_cnt,
    output logic                    proto_err
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic           w_mem_ev;
    logic           w_reg_ev;
    rec_t           w_mem_rec;
    rec_t           w_reg_rec;
    logic [1:0]     w_n_ev;
    logic [LW-1:0]  w_free;
    logic [1:0]     w_n_push;
    logic [1:0]     w_drop;
    logic [16:0]    w_drop_sum;
    logic           w_pop;
    rec_t           w_head;
    logic [LW-1:0]  w_level;
    logic           w_unused;
    logic [15:0]    r_drop_cnt;
    logic           r_proto_err;

    assign w_mem_ev  = capture_en & (wr | rd);
    assign w_reg_ev  = capture_en & reg_write_sig & (reg_num != 5'd0);
    assign w_mem_rec = '{kind: wr ? KIND_MWR : KIND_MRD, tag: addr, data: REC_DW'(wr ? wr_data : rd_data)};
    assign w_reg_rec = '{kind: KIND_REG, tag: {4'b0, reg_num}, data: REC_DW'(reg_data)};

    // space is judged on the pre-edge level; a same-cycle pop never frees a slot
    assign w_n_ev     = {1'b0, w_mem_ev} + {1'b0, w_reg_ev};
    assign w_free     = LW'(DEPTH) - w_level;
    assign w_n_push   = (w_free >= LW'(w_n_ev)) ? w_n_ev : w_free[1:0];
    assign w_drop     = w_n_ev - w_n_push;
    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop);
    assign w_pop      = rec_valid & rec_ready;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_we0   (w_n_push != 2'd0),
        .i_d0    (w_mem_ev ? w_mem_rec : w_reg_rec),
        .i_we1   (w_n_push == 2'd2),
        .i_d1    (w_reg_rec),
        .i_re    (w_pop),
        .o_head  (w_head),
        .o_level (w_level)
    );

    // drop counter saturates; protocol error is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_drop_cnt  <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_proto_err <= r_proto_err | (capture_en & wr & rd);
        end
    end

    assign level     = w_level;
    assign rec_valid = (w_level != '0);
    assign rec_kind  = rec_valid ? w_head.kind : 2'b00;
    assign rec_tag   = rec_valid ? w_head.tag : 9'd0;
    assign rec_data  = rec_valid ? w_head.data[DATA_W-1:0] : '0;
    assign drop_cnt  = r_drop_cnt;
    assign proto_err = r_proto_err;
    assign w_unused  = &{1'b0, w_head.data};

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed self-checking bench for trace_capture
module tb_trace_capture;

    logic        clk;
    logic        reset;
    logic        capture_en;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rec_valid;
    logic        rec_ready;
    logic [1:0]  rec_kind;
    logic [8:0]  rec_tag;
    logic [31:0] rec_data;
    logic [4:0]  level;
    logic [15:0] drop_cnt;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    trace_capture #(.DEPTH(16), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .capture_en    (capture_en),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_kind      (rec_kind),
        .rec_tag       (rec_tag),
        .rec_data      (rec_data),
        .level         (level),
        .drop_cnt      (drop_cnt),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        reg_write_sig = 1'b0;
        reg_num       = 5'd0;
        reg_data      = 32'd0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = 9'd0;
        wr_data       = 32'd0;
        rd_data       = 32'd0;
        rec_ready     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [1:0] k, input logic [8:0] t, input logic [31:0] d);
        chk({tag, "_valid"}, 64'(rec_valid), 64'(1));
        chk({tag, "_kind"}, 64'(rec_kind), 64'(k));
        chk({tag, "_tag"}, 64'(rec_tag), 64'(t));
        chk({tag, "_data"}, 64'(rec_data), 64'(d));
    endtask

    initial begin
        clear_ev();
        capture_en = 1'b1;
        reset      = 1'b1;
        reg_write_sig = 1'b1;
        reg_num       = 5'd3;
        reg_data      = 32'h1111;
        tick();
        tick();
        reset = 1'b0;
        clear_ev();
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_valid", 64'(rec_valid), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_proto", 64'(proto_err), 64'(0));
        chk("rst_kind", 64'(rec_kind), 64'(0));
        chk("rst_tag", 64'(rec_tag), 64'(0));
        chk("rst_data", 64'(rec_data), 64'(0));

        reg_write_sig = 1'b1;
        reg_num       = 5'd5;
        reg_data      = 32'hA5A5_0001;
        tick();
        clear_ev();
        chk_head("reg5", 2'b01, 9'h005, 32'hA5A5_0001);
        chk("reg5_level", 64'(level), 64'(1));

        rec_ready = 1'b1;
        tick();
        chk("pop_level", 64'(level), 64'(0));
        chk("pop_valid", 64'(rec_valid), 64'(0));
        chk("pop_kind", 64'(rec_kind), 64'(0));
        tick();
        chk("empty_pop_level", 64'(level), 64'(0));
        clear_ev();

        wr            = 1'b1;
        addr          = 9'h1F0;
        wr_data       = 32'hDEAD_BEEF;
        reg_write_sig = 1'b1;
        reg_num       = 5'd3;
        reg_data      = 32'd7;
        tick();
        clear_ev();
        chk("dual_level", 64'(level), 64'(2));
        chk_head("dual_first", 2'b10, 9'h1F0, 32'hDEAD_BEEF);
        tick();
        chk_head("dual_hold", 2'b10, 9'h1F0, 32'hDEAD_BEEF);
        rec_ready = 1'b1;
        tick();
        chk_head("dual_second", 2'b01, 9'h003, 32'd7);
        chk("dual_level1", 64'(level), 64'(1));
        tick();
        chk("dual_level0", 64'(level), 64'(0));
        clear_ev();

        reg_write_sig = 1'b1;
        reg_num       = 5'd0;
        reg_data      = 32'h55;
        tick();
        chk("r0_ignored", 64'(level), 64'(0));
        clear_ev();
        capture_en = 1'b0;
        wr         = 1'b1;
        addr       = 9'h010;
        tick();
        chk("cap_off", 64'(level), 64'(0));
        capture_en = 1'b1;
        clear_ev();

        rd      = 1'b1;
        addr    = 9'h055;
        rd_data = 32'h1234_5678;
        wr_data = 32'hFFFF_0000;
        tick();
        clear_ev();
        chk_head("mrd", 2'b11, 9'h055, 32'h1234_5678);
        rec_ready = 1'b1;
        tick();
        clear_ev();
        chk("mrd_pop", 64'(level), 64'(0));

        for (int i = 0; i < 17; i++) begin
            reg_write_sig = 1'b1;
            reg_num       = 5'(i + 1);
            reg_data      = 32'(i);
            tick();
        end
        clear_ev();
        chk("full_level", 64'(level), 64'(16));
        chk("full_drop", 64'(drop_cnt), 64'(1));
        chk_head("full_head", 2'b01, 9'h001, 32'd0);

        wr            = 1'b1;
        addr          = 9'h0AA;
        wr_data       = 32'hCAFE;
        reg_write_sig = 1'b1;
        reg_num       = 5'd9;
        reg_data      = 32'h99;
        rec_ready     = 1'b1;
        tick();
        clear_ev();
        chk("fullpop_level", 64'(level), 64'(15));
        chk("fullpop_drop", 64'(drop_cnt), 64'(3));
        chk_head("fullpop_head", 2'b01, 9'h002, 32'd1);
        rec_ready = 1'b1;
        tick();
        clear_ev();
        chk_head("wrap_head", 2'b01, 9'h003, 32'd2);

        reg_write_sig = 1'b1;
        reg_num       = 5'd20;
        reg_data      = 32'h77;
        rec_ready     = 1'b1;
        tick();
        clear_ev();
        chk("pushpop_level", 64'(level), 64'(14));
        chk_head("pushpop_head", 2'b01, 9'h004, 32'd3);

        for (int i = 0; i < 9; i++) begin
            rec_ready = 1'b1;
            tick();
        end
        clear_ev();
        chk("drain_level", 64'(level), 64'(5));
        chk("drain_drop", 64'(drop_cnt), 64'(3));
        chk_head("drain_head", 2'b01, 9'h00D, 32'd12);

        reset     = 1'b1;
        wr        = 1'b1;
        addr      = 9'h033;
        rec_ready = 1'b1;
        tick();
        reset = 1'b0;
        clear_ev();
        chk("rst2_level", 64'(level), 64'(0));
        chk("rst2_valid", 64'(rec_valid), 64'(0));
        chk("rst2_drop", 64'(drop_cnt), 64'(0));
        tick();
        chk("rst2_after", 64'(level), 64'(0));

        wr      = 1'b1;
        rd      = 1'b1;
        addr    = 9'h004;
        wr_data = 32'h11;
        rd_data = 32'h22;
        tick();
        clear_ev();
        chk("wrrd_level", 64'(level), 64'(1));
        chk_head("wrrd_head", 2'b10, 9'h004, 32'h11);
        chk("wrrd_proto", 64'(proto_err), 64'(1));
        rec_ready = 1'b1;
        tick();
        clear_ev();
        tick();
        chk("proto_sticky", 64'(proto_err), 64'(1));
        chk("proto_level", 64'(level), 64'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("proto_clr", 64'(proto_err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
